clk_en_gen: RTL
===============

Name: clk_en_gen

Overview:
- Parametrised, all-digital successor to the fixed three-output PLL wrapper: NUM_CH independent clock-enable channels derived from the 50 MHz system clock.
- Each channel has a runtime-programmable divide ratio and produces a one-cycle enable strobe plus a 50%-duty divided level.
- A lock indication is qualified by a settle counter; all channels are phase-aligned at lock.
- Sits beside the system PLL. Downstream logic stays on iws_clk_50M and uses the strobes, instead of generating extra clock domains.

Parameters:
- NUM_CH, 3, number of output channels (1..8).
- CNT_W, 16, width of each divide value and channel counter.
- LOCK_CYCLES, 16, number of SETTLE-state cycles before lock (>=1).
- DEF_DIV, {16'd5,16'd2,16'd1}, reset divide values, NUM_CH*CNT_W bits packed, ch0 in LSBs.

Ports:
- iws_clk_50M  input  1  system clock, 50 MHz; the only clock.
- iws_reset_n  input  1  asynchronous, active-low reset.
- iws_enable  input  1  level; high runs the generator.
- iws_load  input  1  one-cycle pulse; captures iws_div into the shadow divide registers.
- iws_div  input  NUM_CH*CNT_W  packed divide values, ch0 in LSBs.
- ows_clk_en  output  NUM_CH  per-channel one-cycle enable strobe.
- ows_clk_div  output  NUM_CH  per-channel divided level, 50% duty (high for ceil(D/2) cycles).
- ows_locked  output  1  high when in LOCKED and the strobes are valid.
- ows_state  output  2  FSM state for debug: 0 IDLE, 1 SETTLE, 2 LOCKED.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; shadow divides = DEF_DIV; all counters 0.
  - ows_clk_en=0, ows_clk_div=0, ows_locked=0, ows_state=0.
- Divide rule: effective D = max(iws_div[ch], 1). Div value 0 behaves as 1.
- FSM (all transitions on the rising edge of iws_clk_50M):
  - IDLE -> SETTLE when iws_enable=1. The settle counter clears to 0.
  - SETTLE counts one per cycle. When the count reaches LOCKED_CYCLES-1, go to LOCKED. ows_locked rises exactly LOCK_CYCLES edges after the edge that entered SETTLE.
  - LOCKED holds while iws_enable=1 and no load.
  - Any state -> IDLE when iws_enable=0. Outputs drop to 0 on that same edge.
- Load handling:
  - iws_load=1 on any edge captures iws_div into the shadow registers.
  - In SETTLE or LOCKED, a load also forces SETTLE with the settle count 0. ows_locked and all outputs drop on that edge.
  - In IDLE, a load only captures; the state stays IDLE.
- Simultaneous events:
  - iws_enable=0 with iws_load=1: go to IDLE and capture the divides.
  - iws_enable rising with iws_load=1: go to SETTLE and capture; the new values are used at lock.
- Channel outputs, registered (cycle k=0 is the first cycle with ows_locked=1):
  - All channel counters are 0 at k=0, so every channel is phase-aligned at lock.
  - ows_clk_en[ch]=1 in cycle k iff (k mod D) == D-1.
  - ows_clk_div[ch]=1 in cycle k iff (k mod D) < ceil(D/2).
  - D=1: strobe every cycle and div level held high.
- Outside LOCKED, ows_clk_en and ows_clk_div are forced to 0 and the counters are held at 0.
- Counters wrap from D-1 to 0. The count never exceeds 2^CNT_W-1.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronously). Shadow divides return to DEF_DIV.

Decomposition:
- Shared package/header holds:
  - FSM state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_LOCKED=2'd2.
  - Default CNT_W.
  - Function computing ceil(D/2).
- Sub-module clk_en_ch, one instance per channel (generate loop).
  - Holds one shadow divide register, its counter, and its strobe/level output registers.
  - Inputs: run, load, div.
- The top level holds the FSM, the settle counter, and the lock output.

Test Plan:
1. Reset, enable=1 at edge 3, LOCK_CYCLES=16, defaults -> ows_locked rises at edge 19. ch0 strobes every cycle; ch1 strobes at k=1,3,5; ch2 strobes at k=4,9 and its div level is high at k=0..2, low at k=3..4.
2. While LOCKED, load iws_div={5,3,0} -> locked drops next edge and returns 16 edges later. ch0 (div 0) behaves as D=1; ch1 strobes at k=2,5; ch2 at k=4,9.
3. enable=0 while LOCKED -> all outputs 0 and state IDLE on that edge. Re-enable -> full 16-cycle settle, then phase-aligned restart.
4. Load pulse in IDLE with {7,7,7}, then enable -> after lock, all three channels strobe together at k=6,13.
5. Async reset asserted mid-LOCKED (between edges) -> outputs 0 without waiting for a clock edge. After release, shadow divides equal DEF_DIV.
6. enable=0 and load=1 on the same edge -> state IDLE, new divides captured. Check that the next lock uses them.

Source files
------------

// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM encodings,
// the default counter width and the ceil(D/2) helper used for the 50% level.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;

    // Divide values up to 32 bits wide; the result always fits in the divide width.
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clk_en_ch.sv
// One clock-enable channel: shadow divide register, phase counter and
// registered strobe / 50%-duty level outputs, all held at 0 while not running.
module clk_en_ch
    import clk_en_gen_pkg::*;
#(
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_D = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             clk_en,
    output logic             clk_div
);

    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;
    logic             run_reg;
    logic             clk_en_reg;
    logic             clk_div_reg;
    logic             clk_en_next;
    logic             clk_div_next;

    assign d_eff = (div_reg == '0) ? CNT_W'(1) : div_reg;
    assign last  = d_eff - CNT_W'(1);
    assign half  = CNT_W'(ceil_half(32'(d_eff)));

    // cnt_reg is the phase of the cycle currently shown on the outputs; the
    // first running cycle always starts at phase 0 so channels align at lock.
    always_comb begin
        cnt_next = '0;
        if (run && run_reg && (cnt_reg < last)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
        clk_en_next  = run && (cnt_next == last);
        clk_div_next = run && (cnt_next < half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= DEF_D;
            cnt_reg     <= '0;
            run_reg     <= 1'b0;
            clk_en_reg  <= 1'b0;
            clk_div_reg <= 1'b0;
        end else begin
            if (load) begin
                div_reg <= div;
            end
            cnt_reg     <= cnt_next;
            run_reg     <= run;
            clk_en_reg  <= clk_en_next;
            clk_div_reg <= clk_div_next;
        end
    end

    assign clk_en  = clk_en_reg;
    assign clk_div = clk_div_reg;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: settle/lock FSM plus one clk_en_ch
// per channel, all running from the single 50 MHz system clock.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int                        NUM_CH      = 3,
    parameter int                        CNT_W       = CNT_W_DEF,
    parameter int                        LOCK_CYCLES = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_DIV     = {16'd5, 16'd2, 16'd1}
) (
    input  logic                      iws_clk_50M,
    input  logic                      iws_reset_n,
    input  logic                      iws_enable,
    input  logic                      iws_load,
    input  logic [NUM_CH*CNT_W-1:0]   iws_div,
    output logic [NUM_CH-1:0]         ows_clk_en,
    output logic [NUM_CH-1:0]         ows_clk_div,
    output logic                      ows_locked,
    output logic [1:0]                ows_state
);

    localparam int            SW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [SW-1:0] settle_reg;
    logic [SW-1:0] settle_next;
    logic          run;

    always_ff @(posedge iws_clk_50M or negedge iws_reset_n) begin
        if (!iws_reset_n) begin
            state_reg  <= ST_IDLE;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
        end
    end

    // Disable wins over everything; a load outside IDLE restarts the settle.
    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        if (!iws_enable) begin
            state_next  = ST_IDLE;
            settle_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                end
                ST_SETTLE: begin
                    if (iws_load) begin
                        settle_next = '0;
                    end else if (settle_reg == SETTLE_LAST) begin
                        state_next  = ST_LOCKED;
                        settle_next = '0;
                    end else begin
                        settle_next = settle_reg + SW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (iws_load) begin
                        state_next  = ST_SETTLE;
                        settle_next = '0;
                    end
                end
                default: begin
                    state_next  = ST_IDLE;
                    settle_next = '0;
                end
            endcase
        end
    end

    // Channels see the upcoming state so their registered outputs line up with ows_locked.
    assign run        = (state_next == ST_LOCKED);
    assign ows_locked = (state_reg == ST_LOCKED);
    assign ows_state  = state_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_en_ch #(
                .CNT_W (CNT_W),
                .DEF_D (DEF_DIV[gi*CNT_W +: CNT_W])
            ) u_ch (
                .clk     (iws_clk_50M),
                .rst_n   (iws_reset_n),
                .run     (run),
                .load    (iws_load),
                .div     (iws_div[gi*CNT_W +: CNT_W]),
                .clk_en  (ows_clk_en[gi]),
                .clk_div (ows_clk_div[gi])
            );
        end
    endgenerate

endmodule
